// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor.
// Holds the FSM state encodings and the default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell.
// Computes x - y - bin, giving the difference bit and the borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, behind a start/done handshake.
// One full-subtractor cell and a borrow flip-flop process one bit per cycle.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             bin;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             bout;
    logic [WIDTH:0]   d_cat;
    logic [WIDTH-1:0] d_next;

    full_subtractor u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (bin),
        .d    (d_bit),
        .bout (bout)
    );

    // Concatenate then drop the LSB so the shift also works when WIDTH is 1.
    assign d_cat  = {d_bit, d_sr};
    assign d_next = d_cat[WIDTH:1];

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // The edge leaving DONE already acts as an IDLE sampling edge, so a held
    // start yields one result every WIDTH+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            bin    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        d_sr  <= '0;
                        bin   <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    d_sr <= d_next;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    bin  <= bout;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff   <= d_next;
                        borrow <= bout;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor.
// Exercises an 8-bit instance and a 1-bit instance sharing clock and reset.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrow8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow1;

    int nchecks = 0;
    int nerrors = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start1),
        .a      (a1),
        .b      (b1),
        .busy   (busy1),
        .done   (done1),
        .diff   (diff1),
        .borrow (borrow1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one 8-bit subtraction and checks latency, busy length and result.
    task automatic applyStimulus(input string tag, input logic [7:0] av, input logic [7:0] bv,
                                 input logic [7:0] exp_diff, input logic exp_borrow);
        int n;
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (busy8 && n < 20) begin
            n++;
            tick();
        end
        checkOutput({tag, "_busy_cycles"}, n, 8);
        checkOutput({tag, "_done"}, done8, 1'b1);
        checkOutput({tag, "_diff"}, diff8, exp_diff);
        checkOutput({tag, "_borrow"}, borrow8, exp_borrow);
        tick();
        checkOutput({tag, "_done_fall"}, done8, 1'b0);
    endtask

    task automatic runWidth1(input string tag, input logic av, input logic bv,
                             input logic exp_diff, input logic exp_borrow);
        a1 = av;
        b1 = bv;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checkOutput({tag, "_busy"}, {busy1, done1}, 2'b10);
        tick();
        checkOutput({tag, "_done"}, done1, 1'b1);
        checkOutput({tag, "_result"}, {diff1, borrow1}, {exp_diff, exp_borrow});
        tick();
        checkOutput({tag, "_done_fall"}, done1, 1'b0);
    endtask

    initial begin
        int ndone;
        int k;
        int first_k;
        int second_k;
        logic [7:0] d_first;
        logic       b_first;
        logic [7:0] d_second;
        logic       b_second;
        logic       stable;

        rst_n  = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        #1;
        checkOutput("reset8", {busy8, done8, diff8, borrow8}, 11'd0);
        checkOutput("reset1", {busy1, done1, diff1, borrow1}, 4'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] basic subtractions");
        applyStimulus("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0);
        applyStimulus("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1);
        applyStimulus("sub_00_ff", 8'h00, 8'hFF, 8'h01, 1'b1);
        applyStimulus("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0);

        $display("[TB] start while busy, operands changed after capture");
        a8 = 8'h80;
        b8 = 8'h01;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'h55;
        b8 = 8'hAA;
        tick();
        tick();
        a8 = 8'hFF;
        b8 = 8'hFF;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        ndone = 0;
        d_first = 8'h00;
        b_first = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (done8) begin
                ndone++;
                d_first = diff8;
                b_first = borrow8;
            end
            tick();
        end
        checkOutput("busy_start_ndone", ndone, 1);
        checkOutput("busy_start_diff", d_first, 8'h7F);
        checkOutput("busy_start_borrow", b_first, 1'b0);

        $display("[TB] reset in the middle of an operation");
        a8 = 8'h10;
        b8 = 8'h20;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_outputs", {busy8, done8, diff8, borrow8}, 11'd0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) ndone++;
            tick();
        end
        checkOutput("midreset_no_done", ndone, 0);
        applyStimulus("sub_10_20", 8'h10, 8'h20, 8'hF0, 1'b1);

        $display("[TB] back-to-back with start held high");
        a8 = 8'h64;
        b8 = 8'h32;
        start8 = 1'b1;
        tick();
        a8 = 8'h01;
        b8 = 8'h02;
        ndone = 0;
        first_k = -1;
        second_k = -1;
        d_first = '0;
        b_first = 1'b1;
        d_second = '0;
        b_second = 1'b0;
        stable = 1'b1;
        k = 0;
        while (ndone < 2 && k < 40) begin
            tick();
            k++;
            if (ndone == 1 && !done8 && (diff8 !== d_first || borrow8 !== b_first)) stable = 1'b0;
            if (done8) begin
                ndone++;
                if (ndone == 1) begin
                    first_k = k;
                    d_first = diff8;
                    b_first = borrow8;
                end else begin
                    second_k = k;
                    d_second = diff8;
                    b_second = borrow8;
                    start8 = 1'b0;
                end
            end
        end
        checkOutput("b2b_ndone", ndone, 2);
        checkOutput("b2b_first_latency", first_k, 8);
        checkOutput("b2b_spacing", second_k - first_k, 9);
        checkOutput("b2b_first_result", {d_first, b_first}, {8'h32, 1'b0});
        checkOutput("b2b_second_result", {d_second, b_second}, {8'hFF, 1'b1});
        checkOutput("b2b_stable", stable, 1'b1);
        tick();
        tick();
        checkOutput("b2b_idle", {busy8, done8}, 2'b00);

        $display("[TB] WIDTH=1 exhaustive");
        runWidth1("w1_00", 1'b0, 1'b0, 1'b0, 1'b0);
        runWidth1("w1_01", 1'b0, 1'b1, 1'b1, 1'b1);
        runWidth1("w1_10", 1'b1, 1'b0, 1'b1, 1'b0);
        runWidth1("w1_11", 1'b1, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
